// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU memory responder: byte-enable constants,
// the posted-write buffer entry and the per-lane merge used by read forwarding.
package cpu_mem_pkg;

    localparam logic [3:0] BE_NONE    = 4'h0;
    localparam logic [3:0] BE_WORD    = 4'hF;
    localparam int         WORD_BYTES = 4;

    // Word address is kept at full 30-bit width so forwarding compares never alias.
    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_wbuf.sv
// One-entry posted-write buffer: holds the last accepted store, drains it to the
// array on the following edge, and forwards buffered and incoming bytes to both read ports.
module mem_write_buffer
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  wbuf_entry_t accept_entry,
    output logic        commit,
    output wbuf_entry_t commit_entry,
    input  logic [29:0] instr_waddr,
    input  logic [31:0] instr_base,
    output logic [31:0] instr_fwd,
    input  logic [29:0] data_waddr,
    input  logic [31:0] data_base,
    output logic [31:0] data_fwd
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state;
    wbuf_entry_t entry;

    // Priority: incoming store over buffered store over array contents.
    function automatic logic [31:0] forward(
        input logic [29:0] waddr,
        input logic [31:0] base,
        input logic        buf_valid,
        input wbuf_entry_t buf_entry,
        input logic        new_valid,
        input wbuf_entry_t new_entry
    );
        logic [31:0] word;
        word = base;
        if (buf_valid && buf_entry.waddr == waddr)
            word = byte_merge(word, buf_entry.data, buf_entry.be);
        if (new_valid && new_entry.waddr == waddr)
            word = byte_merge(word, new_entry.data, new_entry.be);
        return word;
    endfunction

    // A full buffer always drains, so the next state only depends on a new accept.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= accept ? ST_FULL : ST_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (accept) entry <= accept_entry;
    end

    assign commit       = (state == ST_FULL);
    assign commit_entry = entry;

    assign instr_fwd = forward(instr_waddr, instr_base, commit, entry, accept, accept_entry);
    assign data_fwd  = forward(data_waddr,  data_base,  commit, entry, accept, accept_entry);

endmodule

// File: rtl/cpu_mem_responder.sv
// Unified instruction/data memory responder: registered 1-cycle reads on both ports,
// stores posted through a one-entry buffer, sticky error flags and a store counter.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int IDX_W       = 14,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        addr_err,
    output logic        align_err,
    output logic [15:0] store_cnt
);

    logic [31:0] mem [DEPTH_WORDS];

    logic        instr_oor;
    logic        data_oor;
    logic        store_req;
    logic        misalign;
    logic        accept;
    wbuf_entry_t accept_entry;
    logic        commit;
    wbuf_entry_t commit_entry;
    logic [31:0] instr_base;
    logic [31:0] data_base;
    logic [31:0] instr_fwd;
    logic [31:0] data_fwd;

    assign instr_oor = |instr_addr[31:IDX_W+2];
    assign data_oor  = |data_addr[31:IDX_W+2];
    assign store_req = (data_write != BE_NONE);
    assign misalign  = (data_addr[1:0] != 2'b00);
    assign accept    = store_req && !misalign && !data_oor;

    assign accept_entry = '{waddr: data_addr[31:2], data: data_in, be: data_write};

    assign instr_base = mem[instr_addr[IDX_W+1:2]];
    assign data_base  = mem[data_addr[IDX_W+1:2]];

    mem_write_buffer u_wbuf (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept),
        .accept_entry (accept_entry),
        .commit       (commit),
        .commit_entry (commit_entry),
        .instr_waddr  (instr_addr[31:2]),
        .instr_base   (instr_base),
        .instr_fwd    (instr_fwd),
        .data_waddr   (data_addr[31:2]),
        .data_base    (data_base),
        .data_fwd     (data_fwd)
    );

    // A commit pending at reset is discarded; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && commit) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (commit_entry.be[i])
                    mem[commit_entry.waddr[IDX_W-1:0]][8*i +: 8] <= commit_entry.data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_out <= '0;
            data_out  <= '0;
            addr_err  <= 1'b0;
            align_err <= 1'b0;
            store_cnt <= '0;
        end else begin
            if (instr_read) instr_out <= instr_oor ? 32'h0 : instr_fwd;
            if (data_read)  data_out  <= data_oor  ? 32'h0 : data_fwd;
            if ((instr_read && instr_oor) || ((data_read || store_req) && data_oor))
                addr_err <= 1'b1;
            if (store_req && misalign)
                align_err <= 1'b1;
            if (commit && store_cnt != 16'hFFFF)
                store_cnt <= store_cnt + 16'd1;
        end
    end

    // Byte-offset bits of the fetch address and the unused high index bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = &{1'b0, instr_addr[1:0], commit_entry.waddr[29:IDX_W]};

endmodule
